halfadder_checker: RTL and testbench

Synchronous response checker for the half adder: the receiving end of the stimulus interface that drives `a`/`b` into the adder. It watches the adder's inputs and outputs, waits for each new input vector to settle, and compares `s`/`c` against `a^b`/`a&b`. It keeps saturating pass/fail counts, records input coverage, and captures the first failing vector. It sits beside the adder in simulation or on-board self-test and needs no changes to the adder.

---
 rtl/halfadder_checker.sv | 117 +++++++++++
 tb/tb_halfadder_checker.sv | 245 ++++++++++++++++++++++++
 2 files changed

// File: rtl/halfadder_checker.sv
// Response checker for a half adder: waits for each new {a,b} vector to settle,
// then compares s/c against a^b and a&b, accumulating counts, coverage and the first failure.
module halfadder_checker #(
  parameter int SETTLE = 2,
  parameter int CNT_W  = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic             a,
  input  logic             b,
  input  logic             s,
  input  logic             c,
  output logic [CNT_W-1:0] pass_cnt,
  output logic [CNT_W-1:0] fail_cnt,
  output logic [3:0]       cov,
  output logic             all_covered,
  output logic             err_valid,
  output logic [3:0]       err_vec,
  output logic             busy
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SETTLE = 2'd1,
    ST_HOLD   = 2'd2
  } state_t;

  localparam logic [3:0] SETTLE_LAST = 4'(SETTLE - 1);

  state_t           state_q;
  logic [1:0]       ab_prev_q;
  logic [3:0]       settle_cnt_q;
  logic [CNT_W-1:0] pass_cnt_q;
  logic [CNT_W-1:0] fail_cnt_q;
  logic [3:0]       cov_q;
  logic             err_valid_q;
  logic [3:0]       err_vec_q;
  logic             busy_q;

  logic [1:0] ab_now;
  logic       ab_change;
  logic       vec_ok;

  assign ab_now    = {a, b};
  assign ab_change = (ab_now != ab_prev_q);
  assign vec_ok    = (s == (a ^ b)) && (c == (a & b));

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      ab_prev_q    <= 2'b00;
      settle_cnt_q <= 4'd0;
      pass_cnt_q   <= '0;
      fail_cnt_q   <= '0;
      cov_q        <= 4'd0;
      err_valid_q  <= 1'b0;
      err_vec_q    <= 4'd0;
      busy_q       <= 1'b0;
    end else begin
      ab_prev_q <= ab_now;
      if (!en) begin
        // Disabling abandons any pending compare but keeps all results.
        state_q <= ST_IDLE;
        busy_q  <= 1'b0;
      end else begin
        case (state_q)
          ST_IDLE: begin
            state_q      <= ST_SETTLE;
            settle_cnt_q <= 4'd0;
            busy_q       <= 1'b1;
          end
          ST_SETTLE: begin
            if (ab_change) begin
              settle_cnt_q <= 4'd0;
            end else if (settle_cnt_q == SETTLE_LAST) begin
              state_q        <= ST_HOLD;
              busy_q         <= 1'b0;
              cov_q[ab_now]  <= 1'b1;
              if (vec_ok) begin
                if (pass_cnt_q != '1) pass_cnt_q <= pass_cnt_q + CNT_W'(1);
              end else begin
                if (fail_cnt_q != '1) fail_cnt_q <= fail_cnt_q + CNT_W'(1);
                if (!err_valid_q) begin
                  err_valid_q <= 1'b1;
                  err_vec_q   <= {a, b, s, c};
                end
              end
            end else begin
              settle_cnt_q <= settle_cnt_q + 4'd1;
            end
          end
          ST_HOLD: begin
            if (ab_change) begin
              state_q      <= ST_SETTLE;
              settle_cnt_q <= 4'd0;
              busy_q       <= 1'b1;
            end
          end
          default: begin
            state_q <= ST_IDLE;
            busy_q  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign pass_cnt    = pass_cnt_q;
  assign fail_cnt    = fail_cnt_q;
  assign cov         = cov_q;
  assign all_covered = &cov_q;
  assign err_valid   = err_valid_q;
  assign err_vec     = err_vec_q;
  assign busy        = busy_q;

endmodule

// File: tb/tb_halfadder_checker.sv
// Bench for halfadder_checker: a behavioural adder with injectable faults feeds the checker;
// expected compares are queued at stimulus time and matched when the counters move.
module tb_halfadder_checker;
  localparam int SETTLE = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst_n, en, en_sat, a_r, b_r, c_stuck0;
  logic [3:0] s_flip;
  logic       s_w, c_w;

  assign s_w = (a_r ^ b_r) ^ s_flip[{a_r, b_r}];
  assign c_w = c_stuck0 ? 1'b0 : (a_r & b_r);

  logic [15:0] pass_cnt, fail_cnt;
  logic [3:0]  cov, err_vec;
  logic        all_covered, err_valid, busy;

  logic [1:0]  pass_cnt_sat, fail_cnt_sat;
  logic [3:0]  cov_sat, err_vec_sat;
  logic        all_covered_sat, err_valid_sat, busy_sat;

  halfadder_checker #(.SETTLE(SETTLE), .CNT_W(16)) u_dut (
    .clk(clk), .rst_n(rst_n), .en(en), .a(a_r), .b(b_r), .s(s_w), .c(c_w),
    .pass_cnt(pass_cnt), .fail_cnt(fail_cnt), .cov(cov), .all_covered(all_covered),
    .err_valid(err_valid), .err_vec(err_vec), .busy(busy)
  );

  halfadder_checker #(.SETTLE(SETTLE), .CNT_W(2)) u_dut_sat (
    .clk(clk), .rst_n(rst_n), .en(en_sat), .a(a_r), .b(b_r), .s(s_w), .c(c_w),
    .pass_cnt(pass_cnt_sat), .fail_cnt(fail_cnt_sat), .cov(cov_sat),
    .all_covered(all_covered_sat), .err_valid(err_valid_sat), .err_vec(err_vec_sat),
    .busy(busy_sat)
  );

  typedef struct {
    int         edge_no;
    bit         pass;
    logic [3:0] vec;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;
  int   edge_cnt = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  // Scoreboard monitor: any counter movement is one compare and must match the queue head.
  logic [15:0] pass_prev = '0, fail_prev = '0, exp_p, exp_f;
  logic        mon_err_valid;
  logic [3:0]  mon_err_vec, mon_cov;
  exp_t        mon_it;

  always @(negedge clk) begin
    if (mon_on && (pass_cnt !== pass_prev || fail_cnt !== fail_prev)) begin
      checks++;
      if (sb_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_compare edge=%0d pass_cnt=%0d fail_cnt=%0d required no compare",
                 edge_cnt, pass_cnt, fail_cnt);
      end else begin
        mon_it = sb_q.pop_front();
        exp_p  = mon_it.pass ? pass_prev + 16'd1 : pass_prev;
        exp_f  = mon_it.pass ? fail_prev : fail_prev + 16'd1;
        if (!mon_it.pass && !mon_err_valid) begin
          mon_err_valid = 1'b1;
          mon_err_vec   = mon_it.vec;
        end
        mon_cov[mon_it.vec[3:2]] = 1'b1;
        if (edge_cnt !== mon_it.edge_no || pass_cnt !== exp_p || fail_cnt !== exp_f ||
            err_valid !== mon_err_valid || err_vec !== mon_err_vec || cov !== mon_cov) begin
          errors++;
          $display("FAIL compare_event got edge=%0d pass=%0d fail=%0d ev=%b vec=%b cov=%b required edge=%0d pass=%0d fail=%0d ev=%b vec=%b cov=%b",
                   edge_cnt, pass_cnt, fail_cnt, err_valid, err_vec, cov,
                   mon_it.edge_no, exp_p, exp_f, mon_err_valid, mon_err_vec, mon_cov);
        end
      end
    end
    pass_prev = pass_cnt;
    fail_prev = fail_cnt;
  end

  task automatic do_reset();
    mon_on   = 1'b0;
    rst_n    = 1'b0;
    en       = 1'b0;
    en_sat   = 1'b0;
    a_r      = 1'b0;
    b_r      = 1'b0;
    c_stuck0 = 1'b0;
    s_flip   = 4'd0;
    repeat (2) begin @(posedge clk); #1; end
    rst_n = 1'b1;
    sb_q.delete();
    mon_err_valid = 1'b0;
    mon_err_vec   = 4'd0;
    mon_cov       = 4'd0;
    mon_on        = 1'b1;
  endtask

  // Drive a vector after an edge, optionally queue its compare, then hold it for 'hold' edges.
  task automatic apply(input logic [1:0] ab, input int hold, input bit push);
    exp_t it;
    logic sv, cv;
    a_r = ab[1];
    b_r = ab[0];
    if (push) begin
      sv = ab[1] ^ ab[0] ^ s_flip[ab];
      cv = c_stuck0 ? 1'b0 : (ab[1] & ab[0]);
      it.edge_no = edge_cnt + 1 + SETTLE;
      it.vec     = {ab, sv, cv};
      it.pass    = (sv == (ab[1] ^ ab[0])) && (cv == (ab[1] & ab[0]));
      sb_q.push_back(it);
    end
    repeat (hold) begin @(posedge clk); #1; end
  endtask

  task automatic run_sweep();
    en = 1'b1;
    for (int v = 0; v < 4; v++) apply(2'(v), 5, 1'b1);
  endtask

  task automatic test_reset();
    do_reset();
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL reset_pass_cnt got=%0d req=0", pass_cnt); end
    checks++; if (fail_cnt !== 16'd0) begin errors++; $display("FAIL reset_fail_cnt got=%0d req=0", fail_cnt); end
    checks++; if (cov !== 4'd0) begin errors++; $display("FAIL reset_cov got=%b req=0000", cov); end
    checks++; if (all_covered !== 1'b0) begin errors++; $display("FAIL reset_all_covered got=%b req=0", all_covered); end
    checks++; if (err_valid !== 1'b0 || err_vec !== 4'd0) begin errors++; $display("FAIL reset_err got=%b/%b req=0/0000", err_valid, err_vec); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b req=0", busy); end
    $display("test_reset done");
  endtask

  task automatic test_correct_sweep();
    do_reset();
    run_sweep();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL sweep_missing got=%0d pending req=0", sb_q.size()); end
    checks++; if (pass_cnt !== 16'd4 || fail_cnt !== 16'd0) begin errors++; $display("FAIL sweep_counts got=%0d/%0d req=4/0", pass_cnt, fail_cnt); end
    checks++; if (cov !== 4'hF || all_covered !== 1'b1) begin errors++; $display("FAIL sweep_cov got=%b/%b req=1111/1", cov, all_covered); end
    checks++; if (err_valid !== 1'b0) begin errors++; $display("FAIL sweep_err_valid got=%b req=0", err_valid); end
    $display("test_correct_sweep pass=%0d fail=%0d cov=%b", pass_cnt, fail_cnt, cov);
  endtask

  task automatic test_stuck_carry();
    do_reset();
    c_stuck0 = 1'b1;
    run_sweep();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL stuck_missing got=%0d pending req=0", sb_q.size()); end
    checks++; if (pass_cnt !== 16'd3 || fail_cnt !== 16'd1) begin errors++; $display("FAIL stuck_counts got=%0d/%0d req=3/1", pass_cnt, fail_cnt); end
    checks++; if (err_valid !== 1'b1 || err_vec !== 4'b1100) begin errors++; $display("FAIL stuck_err got=%b/%b req=1/1100", err_valid, err_vec); end
    $display("test_stuck_carry pass=%0d fail=%0d err_vec=%b", pass_cnt, fail_cnt, err_vec);
  endtask

  task automatic test_two_faults();
    do_reset();
    s_flip = 4'b0110;
    run_sweep();
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL two_missing got=%0d pending req=0", sb_q.size()); end
    checks++; if (pass_cnt !== 16'd2 || fail_cnt !== 16'd2) begin errors++; $display("FAIL two_counts got=%0d/%0d req=2/2", pass_cnt, fail_cnt); end
    checks++; if (err_valid !== 1'b1 || err_vec !== 4'b0100) begin errors++; $display("FAIL two_err got=%b/%b req=1/0100", err_valid, err_vec); end
    $display("test_two_faults pass=%0d fail=%0d err_vec=%b", pass_cnt, fail_cnt, err_vec);
  endtask

  task automatic test_unstable();
    do_reset();
    en = 1'b1;
    apply(2'b11, 1, 1'b0);
    for (int i = 0; i < 6; i++) begin
      checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unstable_busy step=%0d got=%b req=1", i, busy); end
      apply({((i % 2) == 1) ? 1'b1 : 1'b0, 1'b1}, 1, i == 5);
    end
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL unstable_busy_last got=%b req=1", busy); end
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (sb_q.size() !== 0) begin errors++; $display("FAIL unstable_missing got=%0d pending req=0", sb_q.size()); end
    checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL unstable_final got=%0d/%0d busy=%b req=1/0 busy=0", pass_cnt, fail_cnt, busy); end
    $display("test_unstable pass=%0d", pass_cnt);
  endtask

  task automatic test_enable_reset();
    do_reset();
    en = 1'b1;
    apply(2'b00, 5, 1'b1);
    apply(2'b01, 2, 1'b0);
    en = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    checks++; if (pass_cnt !== 16'd1 || fail_cnt !== 16'd0 || busy !== 1'b0 || cov !== 4'b0001) begin
      errors++; $display("FAIL en_drop got=%0d/%0d busy=%b cov=%b req=1/0 busy=0 cov=0001", pass_cnt, fail_cnt, busy, cov); end
    en = 1'b1;
    apply(2'b01, 5, 1'b1);
    checks++; if (pass_cnt !== 16'd2 || cov !== 4'b0011 || sb_q.size() !== 0) begin
      errors++; $display("FAIL en_reraise got=%0d cov=%b pending=%0d req=2 cov=0011 pending=0", pass_cnt, cov, sb_q.size()); end
    apply(2'b10, 1, 1'b0);
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL mid_settle_busy got=%b req=1", busy); end
    mon_on = 1'b0;
    rst_n  = 1'b0;
    en     = 1'b0;
    @(posedge clk); #1;
    checks++; if (pass_cnt !== 16'd0 || fail_cnt !== 16'd0 || cov !== 4'd0 || all_covered !== 1'b0 ||
                  err_valid !== 1'b0 || err_vec !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset got=%0d/%0d cov=%b ac=%b ev=%b vec=%b busy=%b req all zero",
                         pass_cnt, fail_cnt, cov, all_covered, err_valid, err_vec, busy); end
    rst_n = 1'b1;
    repeat (4) begin @(posedge clk); #1; end
    checks++; if (pass_cnt !== 16'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL post_reset got=%0d busy=%b req=0 busy=0", pass_cnt, busy); end
    $display("test_enable_reset done");
  endtask

  task automatic test_saturation();
    logic [1:0] seq [5];
    int sat_exp;
    seq[0] = 2'b00; seq[1] = 2'b01; seq[2] = 2'b00; seq[3] = 2'b01; seq[4] = 2'b00;
    do_reset();
    en_sat = 1'b1;
    for (int i = 0; i < 5; i++) begin
      apply(seq[i], 5, 1'b0);
      sat_exp = (i + 1 > 3) ? 3 : i + 1;
      checks++; if (int'(pass_cnt_sat) !== sat_exp || fail_cnt_sat !== 2'd0) begin
        errors++; $display("FAIL sat_step%0d got=%0d/%0d req=%0d/0", i, pass_cnt_sat, fail_cnt_sat, sat_exp); end
    end
    checks++; if (cov_sat !== 4'b0011 || all_covered_sat !== 1'b0) begin
      errors++; $display("FAIL sat_cov got=%b/%b req=0011/0", cov_sat, all_covered_sat); end
    checks++; if (pass_cnt !== 16'd0) begin errors++; $display("FAIL sat_main_idle got=%0d req=0", pass_cnt); end
    $display("test_saturation pass=%0d fail=%0d", pass_cnt_sat, fail_cnt_sat);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; en_sat = 1'b0; a_r = 1'b0; b_r = 1'b0;
    c_stuck0 = 1'b0; s_flip = 4'd0;
    test_reset();
    test_correct_sweep();
    test_stuck_carry();
    test_two_faults();
    test_unstable();
    test_enable_reset();
    test_saturation();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
